// File: rtl/rw_nx_ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and byte-lane helpers
// for the rw_nx register bank.
package rw_nx_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;
  localparam logic [1:0] HSIZE_BAD  = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_e;

  function automatic logic is_active(
    input logic [1:0] htrans
  );
    logic act;
    act = 1'b0;
    unique case (htrans)
      HTRANS_IDLE:   act = 1'b0;
      HTRANS_BUSY:   act = 1'b0;
      HTRANS_NONSEQ: act = 1'b1;
      HTRANS_SEQ:    act = 1'b1;
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      HSIZE_BYTE: m = 4'b0001 << a;
      HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      HSIZE_BAD:  m = 4'b0000;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rw_nx_ahb_slv_mem.sv
// Word array with per-byte write enables, async clear
// and one combinational read port.
module rw_nx_ahb_slv_mem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_80m,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_80m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rw_nx_ahb_slv_regbank.sv
// AHB-Lite register/SRAM responder with read wait states,
// two-cycle ERROR responses and a saturating error counter.
import rw_nx_ahb_pkg::*;

module rw_nx_ahb_slv_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_80m,
  input  logic        rst_n,
  input  logic        proc_hsel,
  input  logic [31:0] proc_haddr,
  input  logic [1:0]  proc_htrans,
  input  logic        proc_hwrite,
  input  logic [1:0]  proc_hsize,
  input  logic [31:0] proc_hwdata,
  output logic        proc_hready,
  output logic [1:0]  proc_hresp,
  output logic [31:0] proc_hrdata,
  output logic [7:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = AW + 2;
  localparam logic [3:0] WS_M1 =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e        state;
  logic [3:0]    wcnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [3:0]    wr_be;
  logic          hready_q;
  logic [1:0]    hresp_q;
  logic [31:0]   hrdata_q;
  logic [7:0]    err_q;

  logic          accept;
  logic          in_win;
  logic          aligned;
  logic          legal;
  logic          commit;
  logic [AW-1:0] a_idx;
  logic [AW-1:0] m_raddr;
  logic [3:0]    a_be;
  logic [31:0]   m_rdata;
  logic [31:0]   fwd_data;

  assign accept = hready_q && proc_hsel
               && is_active(proc_htrans);
  assign in_win = proc_haddr[31:BW] == BASE_ADDR[31:BW];
  assign a_idx  = proc_haddr[BW-1:2];
  assign a_be   = lane_mask(proc_hsize, proc_haddr[1:0]);
  assign legal  = in_win && aligned;
  assign commit = state == ST_WR_DATA;

  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      proc_hsize == HSIZE_BYTE: aligned = 1'b1;
      proc_hsize == HSIZE_HALF: aligned = !proc_haddr[0];
      proc_hsize == HSIZE_WORD: aligned = proc_haddr[1:0] == 2'b00;
      default:                  aligned = 1'b0;
    endcase
  end

  assign m_raddr = (state == ST_RD_WAIT) ? rd_idx : a_idx;

  // A read accepted while the previous write commits sees its lanes
  always_comb begin
    fwd_data = m_rdata;
    for (int b = 0; b < 4; b++) begin
      if (commit && wr_be[b] && wr_idx == m_raddr) begin
        fwd_data[8*b +: 8] = proc_hwdata[8*b +: 8];
      end
    end
  end

  rw_nx_ahb_slv_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_80m (clk_80m),
    .rst_n   (rst_n),
    .we      (commit),
    .be      (wr_be),
    .waddr   (wr_idx),
    .wdata   (proc_hwdata),
    .raddr   (m_raddr),
    .rdata   (m_rdata)
  );

  always_ff @(posedge clk_80m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      wr_be    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      hrdata_q <= '0;
      err_q    <= '0;
    end else if (state == ST_RD_WAIT) begin
      if (wcnt == 4'd0) begin
        state    <= ST_RD_DATA;
        hready_q <= 1'b1;
        hrdata_q <= fwd_data;
      end else begin
        wcnt <= wcnt - 4'd1;
      end
    end else if (state == ST_ERR1) begin
      state    <= ST_ERR2;
      hready_q <= 1'b1;
      if (err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end else if (accept) begin
      unique case (1'b1)
        !legal: begin
          state    <= ST_ERR1;
          hready_q <= 1'b0;
          hresp_q  <= HRESP_ERROR;
        end
        legal && proc_hwrite: begin
          state    <= ST_WR_DATA;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          wr_idx   <= a_idx;
          wr_be    <= a_be;
        end
        legal && !proc_hwrite
          && WAIT_STATES == 0: begin
          state    <= ST_RD_DATA;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          hrdata_q <= fwd_data;
        end
        default: begin
          state    <= ST_RD_WAIT;
          hready_q <= 1'b0;
          hresp_q  <= HRESP_OKAY;
          rd_idx   <= a_idx;
          wcnt     <= WS_M1;
        end
      endcase
    end else begin
      state    <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end
  end

  assign proc_hready = hready_q;
  assign proc_hresp  = hresp_q;
  assign proc_hrdata = hrdata_q;
  assign err_cnt     = err_q;

endmodule
